// File: rtl/note_scheduler.sv
// Note-event scheduler: FIFO of (note, octave, duration) events played as a square wave
// using an external tuning lookup. Define NOTE_SCHEDULER_GAP_EN for a one-tick silent gap after each note.
module note_scheduler #(
   parameter int DEPTH    = 4,
   parameter int TICK_DIV = 500000
) (
   input  logic        clock,
   input  logic        resetn,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [3:0]  in_note_name,
   input  logic [3:0]  in_octave,
   input  logic [7:0]  in_duration,
   input  logic        flush,
   output logic [3:0]  lut_note_name,
   output logic [3:0]  lut_octave,
   input  logic [21:0] lut_delay,
   output logic        wave,
   output logic        busy,
   output logic        note_done
);

   // state  | meaning
   // IDLE   | waiting for a queued event; pops the head when one is present
   // LOOKUP | one cycle: capture half period from the tuning lookup
   // PLAY   | square wave running, remaining duration counted in ticks
   // GAP    | one tick of silence after the note (optional build)
   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_LOOKUP = 2'd1;
   localparam logic [1:0] S_PLAY   = 2'd2;
`ifdef NOTE_SCHEDULER_GAP_EN
   localparam logic [1:0] S_GAP    = 2'd3;
`endif

   localparam int AW = $clog2(DEPTH);
   localparam int TW = $clog2(TICK_DIV);
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

   logic [15:0]   r_mem [DEPTH];
   logic [AW:0]   r_wr_ptr;
   logic [AW:0]   r_rd_ptr;
   logic [1:0]    r_state;
   logic [3:0]    r_lut_note;
   logic [3:0]    r_lut_oct;
   logic [7:0]    r_dur;
   logic [21:0]   r_half;
   logic [21:0]   r_half_cnt;
   logic [TW-1:0] r_tick_cnt;
   logic          r_wave;
   logic          r_done;

   logic          w_full;
   logic          w_empty;
   logic          w_push;
   logic          w_tick;
   logic [15:0]   w_head;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_push  = in_valid && !w_full && !flush;
   assign w_head  = r_mem[r_rd_ptr[AW-1:0]];
   assign w_tick  = (r_tick_cnt == TICK_LAST);

   assign in_ready      = !w_full;
   assign busy          = (r_state != S_IDLE);
   assign wave          = r_wave;
   assign note_done     = r_done;
   assign lut_note_name = r_lut_note;
   assign lut_octave    = r_lut_oct;

   always_ff @(posedge clock) begin
      if (w_push) begin
         r_mem[r_wr_ptr[AW-1:0]] <= {in_note_name, in_octave, in_duration};
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_state    <= S_IDLE;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_lut_note <= '0;
         r_lut_oct  <= '0;
         r_dur      <= '0;
         r_half     <= '0;
         r_half_cnt <= '0;
         r_tick_cnt <= '0;
         r_wave     <= 1'b0;
         r_done     <= 1'b0;
      end else if (flush) begin
         r_state    <= S_IDLE;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_dur      <= '0;
         r_half     <= '0;
         r_half_cnt <= '0;
         r_tick_cnt <= '0;
         r_wave     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
         end
         case (r_state)
            S_IDLE: begin
               if (!w_empty) begin
                  r_rd_ptr   <= r_rd_ptr + (AW+1)'(1);
                  r_lut_note <= w_head[15:12];
                  r_lut_oct  <= w_head[11:8];
                  r_dur      <= w_head[7:0];
                  r_state    <= S_LOOKUP;
               end
            end
            S_LOOKUP: begin
               r_half     <= lut_delay >> 1;
               r_half_cnt <= '0;
               r_tick_cnt <= '0;
               if (r_dur == 8'd0) begin
                  r_state <= S_IDLE;
                  r_done  <= 1'b1;
               end else begin
                  r_state <= S_PLAY;
               end
            end
            S_PLAY: begin
               r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TW'(1);
               // A zero half period means an out-of-range note: wave stays low.
               if (r_half != 22'd0) begin
                  if (r_half_cnt == r_half - 22'd1) begin
                     r_half_cnt <= '0;
                     r_wave     <= ~r_wave;
                  end else begin
                     r_half_cnt <= r_half_cnt + 22'd1;
                  end
               end
               if (w_tick) begin
                  r_dur <= r_dur - 8'd1;
                  if (r_dur == 8'd1) begin
                     r_wave     <= 1'b0;
                     r_half_cnt <= '0;
`ifdef NOTE_SCHEDULER_GAP_EN
                     r_state    <= S_GAP;
`else
                     r_state    <= S_IDLE;
                     r_done     <= 1'b1;
`endif
                  end
               end
            end
`ifdef NOTE_SCHEDULER_GAP_EN
            S_GAP: begin
               r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TW'(1);
               if (w_tick) begin
                  r_state <= S_IDLE;
                  r_done  <= 1'b1;
               end
            end
`endif
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
